// File: rtl/fpu_result_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_result_arbiter
//
// Funnels single-cycle result pulses from the FPU sub-units onto the single
// FP register-file writeback port. Each unit owns a one-entry holding buffer,
// so a unit never sees backpressure. A round-robin arbiter picks which
// buffer drives writeback.
//
// Handshake: an entry transfers on a cycle where o_wb_valid && i_wb_ready.
// o_wb_valid never drops and the presented entry never changes while
// i_wb_ready is low. The granted buffer clears on the following edge.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_unit_valid      per-unit result pulse (cannot be stalled)
//   i_unit_result     per-unit result, unit k at [k*DATA_W +: DATA_W]
//   i_unit_dest       per-unit destination register, unit k at [k*5 +: 5]
//   i_unit_flags      per-unit fflags {NV,DZ,OF,UF,NX}, unit k at [k*5 +: 5]
//   o_wb_valid        writeback entry available
//   i_wb_ready        writeback port accepts this cycle
//   o_wb_data/dest/flags/unit  selected entry, all zero when nothing is held
//   o_unit_hold       issue must not start unit k while bit k is set
//   o_pending_regs    one-hot OR of dest regs over all occupied buffers
//   o_overflow        sticky: a pulse hit a full buffer that was not draining
// ---------------------------------------------------------------------------
module fpu_result_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 64,
    parameter int IDX_W     = $clog2(NUM_UNITS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_UNITS-1:0]        i_unit_valid,
    input  logic [NUM_UNITS*DATA_W-1:0] i_unit_result,
    input  logic [NUM_UNITS*5-1:0]      i_unit_dest,
    input  logic [NUM_UNITS*5-1:0]      i_unit_flags,
    output logic                        o_wb_valid,
    input  logic                        i_wb_ready,
    output logic [DATA_W-1:0]           o_wb_data,
    output logic [4:0]                  o_wb_dest,
    output logic [4:0]                  o_wb_flags,
    output logic [IDX_W-1:0]            o_wb_unit,
    output logic [NUM_UNITS-1:0]        o_unit_hold,
    output logic [31:0]                 o_pending_regs,
    output logic                        o_overflow
);

    // One extra bit so rr_ptr + offset can be wrapped without overflow.
    localparam int CW = IDX_W + 1;

    logic [DATA_W-1:0]    buf_data_q  [NUM_UNITS];
    logic [DATA_W-1:0]    buf_data_d  [NUM_UNITS];
    logic [4:0]           buf_dest_q  [NUM_UNITS];
    logic [4:0]           buf_dest_d  [NUM_UNITS];
    logic [4:0]           buf_flags_q [NUM_UNITS];
    logic [4:0]           buf_flags_d [NUM_UNITS];
    logic [NUM_UNITS-1:0] buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
    logic                 overflow_q, overflow_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [CW-1:0]        cand;
    logic                 wb_fire;

    // Winner selection: a locked entry wins unconditionally; otherwise the
    // first occupied buffer at or after rr_ptr (modulo NUM_UNITS).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (lock_valid_q) begin
            win_found = 1'b1;
            win_idx   = lock_idx_q;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                cand = {1'b0, rr_ptr_q} + CW'(i);
                if (cand >= CW'(NUM_UNITS)) begin
                    cand = cand - CW'(NUM_UNITS);
                end
                if (!win_found && buf_valid_q[cand[IDX_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[IDX_W-1:0];
                end
            end
        end
    end

    assign wb_fire = win_found && i_wb_ready;

    // Next-state for buffers, pointer, lock and overflow.
    always_comb begin
        buf_valid_d  = buf_valid_q;
        rr_ptr_d     = rr_ptr_q;
        overflow_d   = overflow_q;
        // Hold the selection whenever an offered entry is not taken.
        lock_valid_d = win_found && !i_wb_ready;
        lock_idx_d   = win_idx;
        for (int k = 0; k < NUM_UNITS; k++) begin
            buf_data_d[k]  = buf_data_q[k];
            buf_dest_d[k]  = buf_dest_q[k];
            buf_flags_d[k] = buf_flags_q[k];
        end

        if (wb_fire) begin
            rr_ptr_d = (win_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : win_idx + 1'b1;
        end

        for (int k = 0; k < NUM_UNITS; k++) begin
            // The granted buffer frees its slot this edge, so a same-cycle
            // pulse can refill it without counting as an overflow.
            if (wb_fire && (win_idx == IDX_W'(k))) begin
                buf_valid_d[k] = 1'b0;
            end
            if (i_unit_valid[k]) begin
                if (!buf_valid_d[k]) begin
                    buf_valid_d[k] = 1'b1;
                    buf_data_d[k]  = i_unit_result[k*DATA_W +: DATA_W];
                    buf_dest_d[k]  = i_unit_dest[k*5 +: 5];
                    buf_flags_d[k] = i_unit_flags[k*5 +: 5];
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_valid_q  <= '0;
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            overflow_q   <= 1'b0;
            for (int k = 0; k < NUM_UNITS; k++) begin
                buf_data_q[k]  <= '0;
                buf_dest_q[k]  <= '0;
                buf_flags_q[k] <= '0;
            end
        end else begin
            buf_valid_q  <= buf_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            overflow_q   <= overflow_d;
            for (int k = 0; k < NUM_UNITS; k++) begin
                buf_data_q[k]  <= buf_data_d[k];
                buf_dest_q[k]  <= buf_dest_d[k];
                buf_flags_q[k] <= buf_flags_d[k];
            end
        end
    end

    // Pending-register map includes register 0; the consumer ignores it.
    always_comb begin
        o_pending_regs = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (buf_valid_q[k]) begin
                o_pending_regs[buf_dest_q[k]] = 1'b1;
            end
        end
    end

    assign o_wb_valid  = win_found;
    assign o_wb_data   = win_found ? buf_data_q[win_idx]  : '0;
    assign o_wb_dest   = win_found ? buf_dest_q[win_idx]  : '0;
    assign o_wb_flags  = win_found ? buf_flags_q[win_idx] : '0;
    assign o_wb_unit   = win_found ? win_idx : '0;
    assign o_unit_hold = buf_valid_q;
    assign o_overflow  = overflow_q;

endmodule
